alaw_channel_scheduler: RTL and testbench

Time-multiplexes one shared combinational A-law compressor (12-bit two's-complement sample in, 8-bit code out) across 2**CHW PCM channels. Requesters present samples with a request line. The scheduler grants them round-robin, drives the encoder, registers its code and hands it downstream with a channel tag under valid/ready backpressure. It sits between the per-channel sample front ends and the framer/serializer.

---
 rtl/alaw_channel_scheduler.sv | 102 ++++++++++
 tb/tb_alaw_channel_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alaw_channel_scheduler.sv
// alaw_channel_scheduler: round-robin time-multiplexer that shares one combinational
// A-law compressor across 2**CHW PCM channels. It grants one requester per IDLE cycle,
// registers the sample into the encoder input, captures the code one cycle later and
// holds it under valid/ready backpressure.
//
// Optional feature macro: ALAW_SCHED_EVEN_INVERT_EN
//   defined   -> out_code carries enc_out ^ 8'h55 (G.711 even-bit inversion)
//   undefined -> out_code carries enc_out unchanged
module alaw_channel_scheduler #(
  parameter int unsigned CHW = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [(1<<CHW)-1:0]         req,
  input  logic [12*(1<<CHW)-1:0]      sample,
  output logic [(1<<CHW)-1:0]         ack,
  output logic [11:0]                 enc_in,
  input  logic [7:0]                  enc_out,
  output logic [7:0]                  out_code,
  output logic [CHW-1:0]              out_ch,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int unsigned N = 1 << CHW;

`ifdef ALAW_SCHED_EVEN_INVERT_EN
  localparam logic [7:0] InvMask = 8'h55;
`else
  localparam logic [7:0] InvMask = 8'h00;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StEncode,
    StHold
  } state_e;

  state_e         state_q;
  logic [CHW-1:0] ptr_q;
  logic [CHW-1:0] grant_q;

  logic [CHW-1:0] pick;
  logic [CHW-1:0] idx;
  logic           found;

  // Round-robin search: first set request at or after ptr_q, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr_q + CHW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Scheduler FSM with all outputs registered; enc_in only changes on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      ack       <= '0;
      enc_in    <= '0;
      out_code  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      ack <= '0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            enc_in    <= sample[12*pick +: 12];
            grant_q   <= pick;
            ack[pick] <= 1'b1;
            // CHW-bit add wraps N-1 back to 0.
            ptr_q     <= pick + 1'b1;
            state_q   <= StEncode;
          end
        end
        StEncode: begin
          out_code  <= enc_out ^ InvMask;
          out_ch    <= grant_q;
          out_valid <= 1'b1;
          state_q   <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alaw_channel_scheduler.sv
// Self-checking bench for alaw_channel_scheduler (CHW=2, four channels) with an
// encoder stub enc_out = enc_in[7:0]. A transaction-level model predicts every
// output each cycle; directed tests add literal expectations on top.
module tb_alaw_channel_scheduler;

  localparam int CHW = 2;
  localparam int N   = 4;

`ifdef ALAW_SCHED_EVEN_INVERT_EN
  localparam logic [7:0] INV = 8'h55;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic              clk;
  logic              reset;
  logic [N-1:0]      req;
  logic [12*N-1:0]   sample;
  logic [N-1:0]      ack;
  logic [11:0]       enc_in;
  logic [7:0]        enc_out;
  logic [7:0]        out_code;
  logic [CHW-1:0]    out_ch;
  logic              out_valid;
  logic              out_ready;

  alaw_channel_scheduler #(.CHW(CHW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .sample    (sample),
    .ack       (ack),
    .enc_in    (enc_in),
    .enc_out   (enc_out),
    .out_code  (out_code),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign enc_out = enc_in[7:0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          m_ptr = 0;
  bit          m_pending = 0;   // granted sample waiting to be encoded
  bit          m_holding = 0;   // code presented downstream, not yet taken
  int          m_g = 0;
  logic [11:0] m_smp = '0;
  logic [N-1:0] exp_ack = '0;
  logic [11:0] exp_enc_in = '0;
  logic [7:0]  exp_code = '0;
  logic [1:0]  exp_ch = '0;
  logic        exp_valid = 1'b0;
  bit          started = 0;

  int ack_cnt = 0;
  int valid_cnt = 0;
  int cyc = 0;
  logic       last_valid = 1'b0;
  logic [1:0] last_ch = '0;
  logic [7:0] last_code = '0;
  int         hs_ch[$];
  int         hs_code[$];
  int         hs_cyc[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (started && !reset && last_valid && out_ready) begin
        hs_ch.push_back(int'(last_ch));
        hs_code.push_back(int'(last_code));
        hs_cyc.push_back(cyc);
      end
      exp_ack = '0;
      if (reset) begin
        started    = 1;
        m_ptr      = 0;
        m_pending  = 0;
        m_holding  = 0;
        exp_enc_in = '0;
        exp_code   = '0;
        exp_ch     = '0;
        exp_valid  = 1'b0;
      end else if (m_holding) begin
        if (out_ready) begin
          m_holding = 0;
          exp_valid = 1'b0;
        end
      end else if (m_pending) begin
        m_pending = 0;
        m_holding = 1;
        exp_valid = 1'b1;
        exp_code  = m_smp[7:0] ^ INV;
        exp_ch    = 2'(m_g);
      end else if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_g = (m_ptr + k) % N;
            break;
          end
        end
        m_smp       = sample[12*m_g +: 12];
        exp_ack     = N'(1) << m_g;
        exp_enc_in  = m_smp;
        m_ptr       = (m_g + 1) % N;
        m_pending   = 1;
      end
      #1;
      if (started) begin
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("enc_in", 32'(enc_in), 32'(exp_enc_in));
        chk("out_code", 32'(out_code), 32'(exp_code));
        chk("out_ch", 32'(out_ch), 32'(exp_ch));
        if (ack != '0) ack_cnt++;
        if (out_valid) valid_cnt++;
      end
      last_valid = out_valid;
      last_ch    = out_ch;
      last_code  = out_code;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input string name, output logic [N-1:0] a);
    a = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        a = ack;
        return;
      end
    end
    chk({name, "_ack_timeout"}, 32'(1), 32'(0));
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    chk({name, "_valid_timeout"}, 32'(1), 32'(0));
  endtask

  task automatic clear_stats();
    ack_cnt = 0;
    valid_cnt = 0;
    hs_ch.delete();
    hs_code.delete();
    hs_cyc.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [N-1:0] a;

  initial begin
    reset     = 1'b1;
    req       = '0;
    sample    = '0;
    out_ready = 1'b1;

    // Reset then idle.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_stats();
    repeat (10) @(negedge clk);
    chk("idle_ack_cnt", 32'(ack_cnt), 32'(0));
    chk("idle_valid_cnt", 32'(valid_cnt), 32'(0));
    chk("idle_enc_in", 32'(enc_in), 32'(0));
    chk("idle_out_code", 32'(out_code), 32'(0));

    // Single request on channel 2.
    clear_stats();
    sample[12*2 +: 12] = 12'h0A5;
    req = 4'b0100;
    wait_ack("single", a);
    chk("single_ack", 32'(a), 32'(4'b0100));
    req = '0;
    repeat (4) @(negedge clk);
    chk("single_ack_cnt", 32'(ack_cnt), 32'(1));
    chk("single_valid_cnt", 32'(valid_cnt), 32'(1));
    chk("single_hs_n", 32'(hs_ch.size()), 32'(1));
    if (hs_ch.size() >= 1) begin
      chk("single_ch", 32'(hs_ch[0]), 32'(2));
      chk("single_code", 32'(hs_code[0]), 32'(8'hA5 ^ INV));
    end

    // Round-robin with all requests held, from the reset pointer.
    pulse_reset();
    clear_stats();
    for (int i = 0; i < N; i++) sample[12*i +: 12] = 12'h010 + 12'(i);
    req = 4'b1111;
    for (int i = 0; i < 40 && hs_ch.size() < 5; i++) @(negedge clk);
    req = '0;
    chk("rr_hs_n", 32'(hs_ch.size() >= 5), 32'(1));
    if (hs_ch.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_ch%0d", k), 32'(hs_ch[k]), 32'(k % N));
        chk($sformatf("rr_code%0d", k), 32'(hs_code[k]), 32'((8'h10 + 8'(k % N)) ^ INV));
        if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(hs_cyc[k] - hs_cyc[k-1]), 32'(3));
      end
    end
    repeat (6) @(negedge clk);

    // Backpressure on channel 1; channel 3 requests while held.
    pulse_reset();
    clear_stats();
    out_ready = 1'b0;
    sample[12*1 +: 12] = 12'h033;
    req = 4'b0010;
    wait_ack("bp", a);
    chk("bp_ack", 32'(a), 32'(4'b0010));
    req = '0;
    wait_valid("bp");
    ack_cnt = 0;
    sample[12*3 +: 12] = 12'h077;
    req = 4'b1000;
    repeat (5) @(negedge clk);
    chk("bp_no_ack_in_hold", 32'(ack_cnt), 32'(0));
    chk("bp_valid_cnt", 32'(valid_cnt), 32'(6));
    chk("bp_code_stable", 32'(out_code), 32'(8'h33 ^ INV));
    out_ready = 1'b1;
    wait_ack("bp_next", a);
    chk("bp_next_ack", 32'(a), 32'(4'b1000));
    req = '0;
    repeat (4) @(negedge clk);

    // Reset in the ENCODE cycle; channel 2 grant would have moved the pointer to 3.
    clear_stats();
    sample[12*2 +: 12] = 12'h044;
    req = 4'b0100;
    wait_ack("mid", a);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_valid_after_reset", 32'(out_valid), 32'(0));
    sample[12*1 +: 12] = 12'h021;
    sample[12*3 +: 12] = 12'h023;
    req = 4'b1010;
    wait_ack("mid_first", a);
    chk("mid_first_grant", 32'(a), 32'(4'b0010));
    req = 4'b1000;
    wait_ack("mid_second", a);
    chk("mid_second_grant", 32'(a), 32'(4'b1000));
    req = '0;
    repeat (4) @(negedge clk);

    // Zero sample on channel 0 exposes the optional inversion mask.
    clear_stats();
    sample[12*0 +: 12] = 12'h000;
    req = 4'b0001;
    wait_ack("zero", a);
    req = '0;
    repeat (4) @(negedge clk);
    chk("zero_hs_n", 32'(hs_ch.size()), 32'(1));
    if (hs_ch.size() >= 1) chk("zero_code", 32'(hs_code[0]), 32'(INV));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
